// File: rtl/jtkiwi_prog_remap.sv
// jtkiwi_prog_remap: ioctl download stage that sorts each byte into an SDRAM
// bank, applies the Kiwi GFX address interleave and queues the byte in a
// 4-entry FIFO. It then issues word-wide SDRAM programming requests with a
// prog_we/prog_rdy handshake.
// Optional feature macro: JTKIWI_PROM_EN. When it is defined, the colour PROM
// region is written through prom_we. When it is not defined, the PROM region
// is folded into bank 3 and prom_we stays low.
module jtkiwi_prog_remap #(
    parameter logic [25:0] BA1_START  = 26'h08000,
    parameter logic [25:0] BA2_START  = 26'h10000,
    parameter logic [25:0] BA3_START  = 26'h50000,
    parameter logic [25:0] PROM_START = 26'h90000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        downloading,
    input  logic [25:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        prom_we,
    output logic        ovf,
    output logic        dwn_done
);

    // addr holds the SDRAM word address. For PROM entries it holds the plain
    // byte offset instead.
    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic        lsb;
        logic [7:0]  data;
        logic        prom;
    } entry_t;

    typedef enum logic [1:0] { IDLE, REQ, GAP } state_t;

    state_t      state;
    entry_t      fifo [0:3];
    logic [1:0]  rd_ptr, wr_ptr;
    logic [2:0]  count;
    logic        dl_q, fell;

    logic [1:0]  in_ba;
    logic [21:0] base, off, off_il;
    logic        in_gfx, in_prom;
    entry_t      in_entry, head;
    logic        push_req, push_ok, pop, have_head;

    // Classify the incoming address into a bank and compute the bank offset.
    // The subtraction is done at 22 bits because the offset is truncated to
    // 22 bits anyway.
    always_comb begin
        in_ba   = 2'd0;
        base    = 22'd0;
        in_gfx  = 1'b0;
        in_prom = 1'b0;
        if (ioctl_addr < BA1_START) begin
            in_ba = 2'd0;
            base  = 22'd0;
        end else if (ioctl_addr < BA2_START) begin
            in_ba = 2'd1;
            base  = BA1_START[21:0];
        end else if (ioctl_addr < BA3_START) begin
            in_ba  = 2'd2;
            base   = BA2_START[21:0];
            in_gfx = 1'b1;
        end else if (ioctl_addr < PROM_START) begin
            in_ba  = 2'd3;
            base   = BA3_START[21:0];
            in_gfx = 1'b1;
        end else begin
`ifdef JTKIWI_PROM_EN
            in_ba   = 2'd0;
            base    = PROM_START[21:0];
            in_prom = 1'b1;
`else
            in_ba = 2'd3;
            base  = BA3_START[21:0];
`endif
        end
        off    = ioctl_addr[21:0] - base;
        off_il = in_gfx ? {off[21:6], off[4:1], off[5], off[0]} : off;

        in_entry.ba   = in_ba;
        in_entry.addr = in_prom ? off_il : {1'b0, off_il[21:1]};
        in_entry.lsb  = off_il[0];
        in_entry.data = ioctl_dout;
        in_entry.prom = in_prom;
    end

    // When the queue is empty, the incoming byte goes straight to the issue
    // logic. This gives single-cycle latency to prog_we.
    always_comb begin
        push_req  = ioctl_wr & downloading;
        have_head = (count != 3'd0) || push_req;
        head      = (count == 3'd0) ? in_entry : fifo[rd_ptr];
        pop       = ((state == REQ) && prog_rdy) ||
                    ((state == IDLE) && have_head && head.prom);
        push_ok   = push_req && ((count != 3'd4) || pop);
    end

    // FIFO storage. Data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (push_ok) fifo[wr_ptr] <= in_entry;
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            if (push_ok && !pop)      count <= count + 3'd1;
            else if (pop && !push_ok) count <= count - 3'd1;
        end
    end

    // Issue FSM. The head entry is latched into the output registers, which
    // keeps the request stable while SDRAM is busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            prog_we   <= 1'b0;
            prom_we   <= 1'b0;
            prog_addr <= 22'd0;
            prog_data <= 16'd0;
            prog_mask <= 2'b11;
            prog_ba   <= 2'd0;
        end else begin
            prom_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (have_head) begin
                        prog_ba   <= head.ba;
                        prog_addr <= head.addr;
                        prog_mask <= head.lsb ? 2'b01 : 2'b10;
                        prog_data <= {head.data, head.data};
                        if (head.prom) begin
                            prom_we <= 1'b1;
                            state   <= GAP;
                        end else begin
                            prog_we <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (prog_rdy) begin
                        prog_we <= 1'b0;
                        state   <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Download edge tracking. It drives the sticky overflow flag and the
    // drain-complete pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dl_q     <= 1'b0;
            fell     <= 1'b0;
            ovf      <= 1'b0;
            dwn_done <= 1'b0;
        end else begin
            dl_q     <= downloading;
            dwn_done <= 1'b0;
            if (downloading && !dl_q) ovf <= 1'b0;
            if (push_req && !push_ok) ovf <= 1'b1;
            if (fell && (count == 3'd0) && (state == IDLE) && !push_req) begin
                dwn_done <= 1'b1;
                fell     <= 1'b0;
            end
            if (!downloading && dl_q) fell <= 1'b1;
        end
    end

endmodule
